// File: rtl/pooling_unit.sv
// Streaming mean/max pooling over a window of SIZE signed Q(IL.FL) elements.
// Each beat carries LANES elements, and a window takes SIZE/LANES beats.
// A completed window updates om and raises done for one cycle.
//
// Handshake: a beat is taken on a rising edge when en=1, flush=0 and
// input_ready=1. im is only looked at on such edges. There is no back-pressure.
// Results are presented as om plus a one-cycle done pulse, and om is held until
// the next window completes.
module pooling_unit #(
  parameter int IL    = 4,
  parameter int FL    = 16,
  parameter int SIZE  = 4,
  parameter int LANES = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 mode,
  input  logic                 flush,
  input  logic [IL+FL-1:0]     im [LANES],
  input  logic                 input_ready,
  output logic [IL+FL-1:0]     om,
  output logic                 done,
  output logic                 busy
);

  localparam int W     = IL + FL;
  localparam int BEATS = SIZE / LANES;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LOG2S = $clog2(SIZE);
  localparam int AW    = W + LOG2S;
  localparam logic [CW-1:0] LAST_CNT = CW'(BEATS - 1);

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic signed [AW-1:0]  acc_q, acc_d;
  logic                  mode_q, mode_d;
  logic [W-1:0]          om_d;
  logic                  done_d, busy_d;

  logic signed [AW-1:0]  lane_sum, sum_all;
  logic signed [W-1:0]   lane_max, run_max, max_all;
  logic [W-1:0]          mean_res;
  logic                  first, last, accept, win_mode;

  // In max mode the accumulator holds the sign-extended running maximum.
  assign run_max  = acc_q[W-1:0];
  assign first    = (cnt_q == '0);
  assign last     = (cnt_q == LAST_CNT);
  assign accept   = en && input_ready && !flush;
  assign win_mode = first ? mode : mode_q;

  // Reduce the lanes of the current beat: sign-extended sum and signed max.
  always_comb begin
    lane_sum = '0;
    lane_max = $signed(im[0]);
    for (int i = 0; i < LANES; i++) begin
      lane_sum = lane_sum + $signed({{LOG2S{im[i][W-1]}}, im[i]});
      if ($signed(im[i]) > lane_max) lane_max = $signed(im[i]);
    end
  end

  // Fold this beat into the window. The first beat starts fresh, and the mean shift floors.
  always_comb begin
    sum_all  = first ? lane_sum : acc_q + lane_sum;
    max_all  = (first || (lane_max > run_max)) ? lane_max : run_max;
    mean_res = W'(sum_all >>> LOG2S);
  end

  // Next-state logic: flush aborts the window, and an accepted beat advances or completes it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mode_d  = mode_q;
    om_d    = om;
    done_d  = 1'b0;
    if (flush) begin
      // Flush is not gated by en. A discard request always clears the partial window.
      state_d = IDLE;
      cnt_d   = '0;
      acc_d   = '0;
    end else if (accept) begin
      if (first) mode_d = mode;
      if (last) begin
        om_d    = win_mode ? max_all : mean_res;
        done_d  = 1'b1;
        state_d = IDLE;
        cnt_d   = '0;
        acc_d   = '0;
      end else begin
        state_d = ACCUM;
        cnt_d   = cnt_q + 1'b1;
        acc_d   = win_mode ? $signed({{LOG2S{max_all[W-1]}}, max_all}) : sum_all;
      end
    end
    busy_d = (cnt_d != '0);
  end

  // State and result registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mode_q  <= 1'b0;
      om      <= '0;
      done    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mode_q  <= mode_d;
      om      <= om_d;
      done    <= done_d;
      busy    <= busy_d;
    end
  end

endmodule

// File: tb/tb_pooling_unit.sv
// Bench for pooling_unit: one single-lane instance (SIZE=4) and one two-lane instance (SIZE=4).
// A window-level reference model collects elements in queues and pools them arithmetically.
module tb_pooling_unit;
  localparam int W    = 20;
  localparam int SIZE = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, en, flush;
  logic         a_mode, a_ready, a_done, a_busy;
  logic [W-1:0] a_im [1];
  logic [W-1:0] a_om;
  logic         b_mode, b_ready, b_done, b_busy;
  logic [W-1:0] b_im [2];
  logic [W-1:0] b_om;

  pooling_unit #(.IL(4), .FL(16), .SIZE(4), .LANES(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(a_mode), .flush(flush),
    .im(a_im), .input_ready(a_ready), .om(a_om), .done(a_done), .busy(a_busy));

  pooling_unit #(.IL(4), .FL(16), .SIZE(4), .LANES(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(b_mode), .flush(flush),
    .im(b_im), .input_ready(b_ready), .om(b_om), .done(b_done), .busy(b_busy));

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  int a_win[$];
  int b_win[$];
  logic a_wmode, b_wmode;
  logic [W-1:0] a_exp_q[$];
  logic [W-1:0] b_exp_q[$];
  logic [W-1:0] a_last = '0;
  logic [W-1:0] b_last = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int to_int(input logic [W-1:0] x);
    return {{(32-W){x[W-1]}}, x};
  endfunction

  // Reference pooling: floor of the exact mean, or the plain maximum.
  function automatic logic [W-1:0] pool(input int q[$], input logic m);
    int s, mx, d;
    s  = 0;
    mx = q[0];
    foreach (q[i]) begin
      s += q[i];
      if (q[i] > mx) mx = q[i];
    end
    d = s / SIZE;
    if ((s % SIZE) != 0 && s < 0) d = d - 1;
    return m ? mx[W-1:0] : d[W-1:0];
  endfunction

  // ---------------- driver tasks ----------------
  // One clock: update the model from the inputs seen at the edge, then check both DUTs.
  task automatic step();
    logic a_de, b_de;
    a_de = 1'b0;
    b_de = 1'b0;
    @(posedge clk);
    if (rst_n) begin
      if (flush) begin
        a_win.delete();
        b_win.delete();
      end else if (en) begin
        if (a_ready) begin
          if (a_win.size() == 0) a_wmode = a_mode;
          a_win.push_back(to_int(a_im[0]));
          if (a_win.size() == SIZE) begin
            a_exp_q.push_back(pool(a_win, a_wmode));
            a_win.delete();
            a_de = 1'b1;
          end
        end
        if (b_ready) begin
          if (b_win.size() == 0) b_wmode = b_mode;
          b_win.push_back(to_int(b_im[0]));
          b_win.push_back(to_int(b_im[1]));
          if (b_win.size() == SIZE) begin
            b_exp_q.push_back(pool(b_win, b_wmode));
            b_win.delete();
            b_de = 1'b1;
          end
        end
      end
    end
    #1;
    check("a_done", a_done, a_de);
    if (a_de) a_last = a_exp_q.pop_front();
    check("a_om", a_om, a_last);
    check("a_busy", a_busy, a_win.size() != 0);
    check("b_done", b_done, b_de);
    if (b_de) b_last = b_exp_q.pop_front();
    check("b_om", b_om, b_last);
    check("b_busy", b_busy, b_win.size() != 0);
  endtask

  task automatic a_beat(input logic [W-1:0] x, input logic m);
    a_ready = 1'b1;
    a_im[0] = x;
    a_mode  = m;
    step();
    a_ready = 1'b0;
  endtask

  task automatic b_beat(input logic [W-1:0] x0, input logic [W-1:0] x1, input logic m);
    b_ready = 1'b1;
    b_im[0] = x0;
    b_im[1] = x1;
    b_mode  = m;
    step();
    b_ready = 1'b0;
  endtask

  task automatic a_window(input logic [W-1:0] x0, input logic [W-1:0] x1,
                          input logic [W-1:0] x2, input logic [W-1:0] x3, input logic m);
    a_beat(x0, m);
    a_beat(x1, m);
    a_beat(x2, m);
    a_beat(x3, m);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_a_om"}, a_om, 20'd0);
    check({tag, "_a_done"}, a_done, 1'b0);
    check({tag, "_a_busy"}, a_busy, 1'b0);
    check({tag, "_b_om"}, b_om, 20'd0);
    check({tag, "_b_done"}, b_done, 1'b0);
    check({tag, "_b_busy"}, b_busy, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; en = 1'b1; flush = 1'b0;
    a_mode = 1'b0; a_ready = 1'b0; a_im[0] = '0;
    b_mode = 1'b0; b_ready = 1'b0; b_im[0] = '0; b_im[1] = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Mean of a positive window; done must drop on the following idle cycle.
    a_window(20'd520, 20'd360, 20'd1378, 20'd280, 1'b0);
    check("tp_mean", a_om, 20'd634);
    step();

    // Max of the same data, then a window whose mode flips after beat 2.
    a_window(20'd520, 20'd360, 20'd1378, 20'd280, 1'b1);
    check("tp_max", a_om, 20'd1378);
    a_beat(20'd10, 1'b1);
    a_beat(-20'sd5, 1'b1);
    a_beat(20'd100, 1'b0);
    a_beat(20'd50, 1'b0);
    check("tp_mode_latch", a_om, 20'd100);

    // Negative mean floors toward minus infinity.
    a_window(-20'sd8, -20'sd3, 20'd0, 20'd1, 1'b0);
    check("tp_neg_mean", a_om, 20'hFFFFD);
    step();

    // Two lanes per beat, then three back-to-back windows.
    b_beat(20'd520, 20'd360, 1'b0);
    b_beat(20'd1378, 20'd280, 1'b0);
    check("tp_lanes2", b_om, 20'd634);
    for (int i = 0; i < 6; i++)
      b_beat(W'($urandom_range(0, (1 << W) - 1)), W'($urandom_range(0, (1 << W) - 1)), i >= 2 && i < 4);
    step();

    // en low for 5 cycles mid-window must not disturb anything.
    a_beat(20'd520, 1'b0);
    a_beat(20'd360, 1'b0);
    en = 1'b0;
    a_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a_im[0] = W'($urandom_range(0, (1 << W) - 1));
      a_mode  = 1'b1;
      step();
    end
    en = 1'b1;
    a_ready = 1'b0;
    a_beat(20'd1378, 1'b0);
    a_beat(20'd280, 1'b0);
    check("tp_en_hold", a_om, 20'd634);

    // flush after two beats discards them even with input_ready high.
    a_beat(20'd7, 1'b1);
    a_beat(20'd9, 1'b1);
    flush = 1'b1;
    a_ready = 1'b1;
    a_im[0] = 20'd99999;
    step();
    flush = 1'b0;
    a_ready = 1'b0;
    check("tp_flush_om", a_om, 20'd634);
    a_window(20'd4, 20'd8, 20'd12, 20'd16, 1'b0);
    check("tp_after_flush", a_om, 20'd10);

    // Asynchronous reset between edges, mid-window.
    a_beat(20'd500, 1'b1);
    a_beat(20'd600, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    a_win.delete(); b_win.delete();
    a_exp_q.delete(); b_exp_q.delete();
    a_last = '0; b_last = '0;
    @(negedge clk);
    rst_n = 1'b1;
    a_window(20'd520, 20'd360, 20'd1378, 20'd280, 1'b0);
    check("tp_after_rst", a_om, 20'd634);

    // Randomized traffic on both instances.
    for (int i = 0; i < 400; i++) begin
      en      = ($urandom_range(0, 9) != 0);
      flush   = en && ($urandom_range(0, 24) == 0);
      a_ready = ($urandom_range(0, 3) != 0);
      b_ready = ($urandom_range(0, 3) != 0);
      a_mode  = 1'($urandom_range(0, 1));
      b_mode  = 1'($urandom_range(0, 1));
      a_im[0] = W'($urandom_range(0, (1 << W) - 1));
      b_im[0] = W'($urandom_range(0, (1 << W) - 1));
      b_im[1] = W'($urandom_range(0, (1 << W) - 1));
      step();
    end
    en = 1'b1; flush = 1'b0; a_ready = 1'b0; b_ready = 1'b0;
    step();

    // ---------------- final report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pooling_unit.md
# pooling_unit

Parametrised streaming pooling block for the SPRING fixed-point datapath. It reduces a window of SIZE signed Q(IL.FL) elements to one output using mean or max pooling, selected per window. Elements arrive LANES per beat over SIZE/LANES beats, and each result is flagged by a one-cycle done pulse. It sits between the activation stage and the next layer's input buffer, and supersedes the fixed four-element mean pooler.

## Interface
- IL, 4, integer bits of each element, sign included
- FL, 16, fractional bits of each element
- SIZE, 4, elements per pooling window; power of two, ≥2
- LANES, 1, elements accepted per beat; power of two that divides SIZE
- clk  input  1  clock, rising edge active
- rst_n  input  1  asynchronous active-low reset
- en  input  1  block enable; when 0, beats are ignored and state is held
- mode  input  1  0 = mean, 1 = max; sampled on the first beat of each window
- flush  input  1  discards the partial window (synchronous)
- im  input  [IL+FL-1:0] x LANES  unpacked array of input elements, signed two's complement
- input_ready  input  1  im is valid this cycle (beat strobe)
- om  output  IL+FL  pooled result, signed Q(IL.FL)
- done  output  1  one-cycle pulse: om updated this cycle
- busy  output  1  a partial window is held (beat count ≠ 0)

## Operation
- A beat is accepted when rst_n=1, en=1, flush=0 and input_ready=1.
- The beat counter runs 0..SIZE/LANES-1 and is log2(SIZE/LANES) bits wide (minimum 1).
- FSM has two states:
  - IDLE: count=0.
  - ACCUM: 0<count<SIZE/LANES.
  - IDLE→ACCUM on an accepted beat when SIZE/LANES>1.
  - ACCUM→IDLE on the last accepted beat, or on flush.
- The first beat of a window latches mode into mode_q. Changes to mode mid-window are ignored.
- Mean mode:
  - Accumulator is signed, IL+FL+log2(SIZE) bits.
  - First beat loads the sign-extended sum of its lanes; later beats add the sign-extended lane sum.
  - On the last beat, result = (acc + lane sum) >>> log2(SIZE): arithmetic shift, truncating toward −∞, no rounding.
  - The result always fits in IL+FL bits, so no saturation is needed.
- Max mode:
  - Running max uses signed compare over all lanes and beats.
  - First beat loads the max of its lanes.
  - On the last beat, result = max(running max, lane max).
- Last beat: om ← result and done ← 1 on the same clock edge. The counter and accumulator return to zero, and the next window's first beat may be accepted on the following cycle (no bubble).
- om holds its value until the next completed window.
- flush: counter and accumulator go to 0, no done pulse, om is unchanged. flush overrides input_ready in the same cycle.
- en=0: counter, accumulator and om are held. done still falls after its single cycle.
- When SIZE=LANES, every accepted beat completes a window and the FSM never leaves IDLE.

## Timing
- Reset (rst_n=0, asynchronous): om=0, done=0, busy=0, count=0, accumulator=0, mode_q=0.
- Reset asserted mid-window discards the partial window. The first accepted beat after release starts a new window.
- Latency: the last beat is sampled at edge N; om and done are valid after edge N; done falls after edge N+1 unless edge N+1 completes another window.
- Throughput: one window per SIZE/LANES cycles under continuous input_ready. done may then be high on consecutive cycles when SIZE=LANES.
- busy is registered and equals (count≠0) after each edge.
- im is sampled only on edges where a beat is accepted; it may change freely otherwise.

## Test plan
- IL=4, FL=16, SIZE=4, LANES=1, mode=0: im=520, 360, 1378, 280 on four consecutive beats → om=634 and done=1 for exactly one cycle after the 4th edge; busy=1 after beats 1–3 and 0 after beat 4.
- Same stimulus with mode=1 → om=1378. Then mode toggled to 0 after beat 2 of the next window → that window is still max-pooled.
- Signed mean: −8, −3, 0, 1 (20-bit two's complement) with mode=0 → om=−3 (0xFFFFD), showing truncation toward −∞.
- LANES=2, SIZE=4: beats {520,360} then {1378,280} → om=634 after the 2nd edge. Continuous input_ready over 3 windows → done every 2nd cycle with no gaps.
- Hold and abort:
  - en=0 between beats 2 and 3 for 5 cycles → no state change, result identical to the uninterrupted case.
  - flush after beat 2 → busy=0, no done, om unchanged; the next 4 beats give a correct fresh result.
- rst_n pulsed low asynchronously mid-window (between edges) → om=0, done=0 and busy=0 immediately; after release, a full window of 4 beats gives the correct result.
